// File: rtl/sram_responder_pkg.sv
// Shared definitions for the data-memory responder and its wait-state counter.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } mem_state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;
    localparam int          SRAM_DW           = 16;
    localparam int          WAIT_CNT_W        = 4;

    function automatic logic isPhase(input mem_state_e state);
        return (state == LOW) || (state == HIGH);
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// CPU request side plus SRAM pad side of the data-memory responder.
interface sram_responder_if
    import arm_mem_pkg::*;
#(
    parameter int SRAM_AW = 18
) ();

    logic                 wr_en;
    logic                 rd_en;
    logic [31:0]          address;
    logic [31:0]          write_data;
    logic [31:0]          read_data;
    logic                 ready;
    logic [SRAM_AW-1:0]   sram_addr;
    logic [SRAM_DW-1:0]   sram_dq_out;
    logic                 sram_dq_oe;
    logic [SRAM_DW-1:0]   sram_dq_in;
    logic                 sram_we_n;

    modport slave (
        input  wr_en, rd_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport master (
        output wr_en, rd_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

endinterface

// File: rtl/sram_responder_wait_counter.sv
// Wait-state counter: counts phase cycles and flags the final one (count == WAIT_CYCLES).
module wait_counter
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  enable_i,
    output logic [WAIT_CNT_W-1:0] count_o,
    output logic                  last_o
);

    logic [WAIT_CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst || clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + WAIT_CNT_W'(1);
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == WAIT_CNT_W'(WAIT_CYCLES));

endmodule

// File: rtl/sram_responder.sv
// Serves 32-bit CPU loads/stores as two half-word cycles on a 16-bit asynchronous SRAM.
module sram_responder
    import arm_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    sram_responder_if.slave  bus
);

    localparam logic [WAIT_CNT_W-1:0] NEAR_LAST = WAIT_CNT_W'(WAIT_CYCLES - 1);

    mem_state_e             state_q;
    logic                   isStore_q;
    logic [SRAM_AW-2:0]     word_q;
    logic [31:0]            data_q;
    logic [31:0]            readData_q;
    logic [SRAM_AW-1:0]     sramAddr_q;
    logic [SRAM_DW-1:0]     dqOut_q;
    logic                   dqOe_q;
    logic                   weN_q;

    logic [SRAM_AW-2:0]     reqWord_d;
    logic                   request_d;
    logic                   ready_d;
    logic                   cntClear;
    logic                   cntEnable;
    logic                   cntLast;
    logic [WAIT_CNT_W-1:0]  cntValue;

    // Word index is the low bits of (address - BASE_ADDR); upper bits drop so it wraps.
    assign reqWord_d = bus.address[SRAM_AW:2] - BASE_ADDR[SRAM_AW:2];
    assign request_d = bus.wr_en | bus.rd_en;

    assign cntEnable = isPhase(state_q);
    assign cntClear  = (state_q == IDLE) || (cntEnable && cntLast);

    wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_waitCounter (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (cntClear),
        .enable_i (cntEnable),
        .count_o  (cntValue),
        .last_o   (cntLast)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            isStore_q  <= 1'b0;
            word_q     <= '0;
            data_q     <= '0;
            readData_q <= '0;
            sramAddr_q <= '0;
            dqOut_q    <= '0;
            dqOe_q     <= 1'b0;
            weN_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (request_d) begin
                        state_q    <= LOW;
                        isStore_q  <= bus.wr_en;
                        word_q     <= reqWord_d;
                        data_q     <= bus.write_data;
                        sramAddr_q <= {reqWord_d, 1'b0};
                        dqOut_q    <= bus.write_data[SRAM_DW-1:0];
                        dqOe_q     <= bus.wr_en;
                        weN_q      <= !bus.wr_en;
                    end
                end
                // Strobe is released one cycle early so address and data are held past its rising edge.
                LOW: begin
                    if (cntLast) begin
                        if (!isStore_q) begin
                            readData_q[15:0] <= bus.sram_dq_in;
                        end
                        state_q    <= HIGH;
                        sramAddr_q <= {word_q, 1'b1};
                        dqOut_q    <= data_q[31:16];
                        weN_q      <= !isStore_q;
                    end else if (cntValue == NEAR_LAST) begin
                        weN_q <= 1'b1;
                    end
                end
                HIGH: begin
                    if (cntLast) begin
                        if (!isStore_q) begin
                            readData_q[31:16] <= bus.sram_dq_in;
                        end
                        state_q <= DONE;
                        dqOe_q  <= 1'b0;
                        weN_q   <= 1'b1;
                    end else if (cntValue == NEAR_LAST) begin
                        weN_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ready_d = 1'b0;
        case (state_q)
            IDLE:    ready_d = !request_d;
            DONE:    ready_d = 1'b1;
            default: ready_d = 1'b0;
        endcase
    end

    assign bus.ready       = ready_d;
    assign bus.read_data   = readData_q;
    assign bus.sram_addr   = sramAddr_q;
    assign bus.sram_dq_out = dqOut_q;
    assign bus.sram_dq_oe  = dqOe_q;
    assign bus.sram_we_n   = weN_q;

endmodule
